// File: rtl/diag_matmul_sequencer.sv
// diag_matmul_sequencer
//
// Computes C = diag(A) * B for an N-element diagonal A and an N x M matrix B.
// The job runs in three phases:
//   1. Load all N elements of A into a local register file.
//   2. Stream B in row-major order, producing one C element per B element.
//   3. Wait for the last C element to be accepted downstream.
//
// Each C element is one signed 32 x 32 multiply. It is registered, so a C
// result appears one cycle after the B element that produced it.
//
// Optional feature (compile-time macro DIAG_MATMUL_SAT_EN):
//   - Defined: the product saturates to the int32 range.
//   - Undefined: the product keeps its low 32 bits (two's-complement wrap).
//
// Ports:
//   clk, rst_n      : clock; synchronous active-low reset
//   start           : one-cycle job request (only honoured when idle)
//   busy, done      : busy from job accept to completion; done pulses once
//   a_valid/a_ready : diagonal element handshake, data on a_data
//   b_valid/b_ready : matrix element handshake, data on b_data (row-major)
//   c_valid/c_ready : result handshake, data on c_data; c_last marks C[N-1][M-1]
module diag_matmul_sequencer #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        c_valid,
    output logic [31:0] c_data,
    input  logic        c_ready,
    output logic        c_last
);

    localparam int unsigned KW = $clog2(N);
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);
    localparam logic [CW-1:0] CLast = CW'(M - 1);

    typedef enum logic [1:0] {StIdle, StLoadA, StStream, StFlush} state_e;

    state_e state_q, state_d;

    logic [KW-1:0] k_q;
    logic [KW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          c_valid_q;
    logic          c_last_q;
    logic [31:0]   c_data_q;

    logic signed [31:0] a_reg [N];
    logic signed [31:0] a_sel;
    logic signed [31:0] b_sig;
    logic [31:0]        product;
    logic               a_xfer;
    logic               b_xfer;
    logic               out_free;
    logic               at_end;

    assign a_sel    = a_reg[row_q];
    assign b_sig    = b_data;
    assign out_free = !c_valid_q || c_ready;
    assign at_end   = (row_q == KLast) && (col_q == CLast);
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    assign busy     = (state_q != StIdle);
    assign c_valid  = c_valid_q;
    assign c_data   = c_data_q;
    assign c_last   = c_last_q;

`ifdef DIAG_MATMUL_SAT_EN
    logic signed [63:0] prod_full;

    // Both operands are sign-extended to 64 bits before the multiply,
    // because the left-hand side is 64 bits wide.
    assign prod_full = a_sel * b_sig;

    // The result fits in int32 only if bits 63..31 are all copies of the sign.
    always_comb begin
        product = prod_full[31:0];
        if (prod_full[63:31] != {33{prod_full[63]}}) begin
            product = prod_full[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    // The low 32 bits of a signed product do not depend on the high half.
    assign product = a_sel * b_sig;
`endif

    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        b_ready = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoadA;
            end
            StLoadA: begin
                a_ready = 1'b1;
                if (a_valid && (k_q == KLast)) state_d = StStream;
            end
            StStream: begin
                b_ready = out_free;
                if (b_valid && out_free && at_end) state_d = StFlush;
            end
            StFlush: begin
                if (c_valid_q && c_ready && c_last_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            c_valid_q <= 1'b0;
            c_last_q  <= 1'b0;
            c_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (a_xfer) begin
                k_q <= (k_q == KLast) ? '0 : k_q + KW'(1);
            end
            if (b_xfer) begin
                if (col_q == CLast) begin
                    col_q <= '0;
                    row_q <= (row_q == KLast) ? '0 : row_q + KW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                c_valid_q <= 1'b1;
                c_data_q  <= product;
                c_last_q  <= at_end;
            end else if (c_ready) begin
                c_valid_q <= 1'b0;
                c_last_q  <= 1'b0;
            end
        end
    end

    // No reset: a_reg is always fully reloaded before it is read.
    always_ff @(posedge clk) begin
        if (a_xfer) a_reg[k_q] <= a_data;
    end

endmodule
